// File: rtl/wm8731_cfg_seq.sv
// wm8731_cfg_seq
//   Configuration sequencer that sits upstream of the i2cc I2C master. After
//   reset (when AUTO_START=1) or on a start pulse, it walks a fixed 11-entry
//   WM8731 register table. For each entry it presents the 24-bit word
//   {DEV_ADDR, reg[6:0], data[8:0]} to i2cc, issues a one-cycle write strobe,
//   and follows i2cc's idle flag until the transfer is finished. If i2cc does
//   not accept a strobe in time, the strobe is retried; when the retries run
//   out, the run is abandoned with a sticky error.
//
// Ports
//   clk        system clock
//   reset      asynchronous, active-low reset
//   start      one-cycle pulse that reruns the table (ignored unless idle)
//   i2c_idle   i2cc idle flag, 1 = free
//   i2c_din    word for i2cc, held stable from the strobe to the end of the transfer
//   i2c_wr     one-cycle write strobe to i2cc
//   busy       a table run is in progress
//   done       sticky, every entry has been sent; cleared by the next start
//   error      sticky, accept timeout after the retries; cleared by the next start
//   cfg_index  index of the current or last table entry
module wm8731_cfg_seq #(
  parameter logic [7:0] DEV_ADDR       = 8'h34,
  parameter int         STARTUP_CYCLES = 1000,
  parameter int         GAP_CYCLES     = 50,
  parameter int         ACCEPT_CYCLES  = 16,
  parameter int         MAX_RETRY      = 2,
  parameter bit         AUTO_START     = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        i2c_idle,
  output logic [23:0] i2c_din,
  output logic        i2c_wr,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [3:0]  cfg_index
);

  localparam int CNT_W = 16;
  localparam int RTY_W = 4;

  localparam logic [2:0] S_RESET_WAIT = 3'd0;
  localparam logic [2:0] S_IDLE       = 3'd1;
  localparam logic [2:0] S_LOAD       = 3'd2;
  localparam logic [2:0] S_STROBE     = 3'd3;
  localparam logic [2:0] S_WAIT_ACC   = 3'd4;
  localparam logic [2:0] S_WAIT_DONE  = 3'd5;
  localparam logic [2:0] S_GAP        = 3'd6;

  localparam logic [3:0] LAST_INDEX = 4'd10;

  // Terminal counts. The startup count runs one cycle longer than the gap
  // count because the startup counter is already running in the cycle of
  // reset release, whereas the gap counter is loaded on the entering edge;
  // both then give a strobe latency of N+2 cycles from the triggering event.
  localparam logic [CNT_W-1:0] STARTUP_LAST = CNT_W'(STARTUP_CYCLES);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] ACCEPT_LAST  = CNT_W'(ACCEPT_CYCLES - 1);
  localparam logic [RTY_W-1:0] RETRY_MAX    = RTY_W'(MAX_RETRY);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RTY_W-1:0] retry_q, retry_d;
  logic [23:0]      din_q, din_d;
  logic [3:0]       index_q, index_d;
  logic             done_q, done_d;
  logic             error_q, error_d;

  // Register table: {reg[6:0], data[8:0]} for each entry.
  function automatic logic [15:0] table_entry(input logic [3:0] idx);
    case (idx)
      4'd0:    table_entry = {7'd15, 9'h000};
      4'd1:    table_entry = {7'd6,  9'h000};
      4'd2:    table_entry = {7'd0,  9'h017};
      4'd3:    table_entry = {7'd1,  9'h017};
      4'd4:    table_entry = {7'd2,  9'h079};
      4'd5:    table_entry = {7'd3,  9'h079};
      4'd6:    table_entry = {7'd4,  9'h012};
      4'd7:    table_entry = {7'd5,  9'h000};
      4'd8:    table_entry = {7'd7,  9'h002};
      4'd9:    table_entry = {7'd8,  9'h000};
      4'd10:   table_entry = {7'd9,  9'h001};
      default: table_entry = 16'h0000;
    endcase
  endfunction

  // Sequencer next-state logic. The output word is only reloaded in LOAD, so
  // it stays frozen through strobe, retries, the transfer and the gap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    din_d   = din_q;
    index_d = index_q;
    done_d  = done_q;
    error_d = error_q;
    case (state_q)
      S_RESET_WAIT: begin
        if (cnt_q == STARTUP_LAST) begin
          cnt_d   = '0;
          state_d = AUTO_START ? S_LOAD : S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_IDLE: begin
        if (start) begin
          done_d  = 1'b0;
          error_d = 1'b0;
          index_d = '0;
          retry_d = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        din_d = {DEV_ADDR, table_entry(index_q)};
        if (i2c_idle) begin
          state_d = S_STROBE;
        end
      end
      S_STROBE: begin
        cnt_d   = '0;
        state_d = S_WAIT_ACC;
      end
      S_WAIT_ACC: begin
        // i2cc signals acceptance by dropping idle; otherwise retry or give up.
        if (!i2c_idle) begin
          state_d = S_WAIT_DONE;
        end else if (cnt_q == ACCEPT_LAST) begin
          cnt_d = '0;
          if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + 1'b1;
            state_d = S_STROBE;
          end else begin
            error_d = 1'b1;
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (i2c_idle) begin
          cnt_d   = '0;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (index_q == LAST_INDEX) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            index_d = index_q + 4'd1;
            retry_d = '0;
            state_d = S_LOAD;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset aborts any transfer immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_RESET_WAIT;
      cnt_q   <= '0;
      retry_q <= '0;
      din_q   <= '0;
      index_q <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      din_q   <= din_d;
      index_q <= index_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  assign i2c_din   = din_q;
  assign i2c_wr    = (state_q == S_STROBE);
  assign busy      = (state_q != S_RESET_WAIT) && (state_q != S_IDLE);
  assign done      = done_q;
  assign error     = error_q;
  assign cfg_index = index_q;

endmodule

// File: tb/tb_wm8731_cfg_seq.sv
// Testbench for wm8731_cfg_seq. An i2cc stand-in answers each strobe by
// dropping idle after a short random delay and holding it low for a random
// transfer length; it can also be forced to stay high or stay low. Strobes and
// idle rises are logged with cycle stamps and compared against the expected
// register words and the documented latencies.
module tb_wm8731_cfg_seq;

  localparam int STARTUP = 1000;
  localparam int GAP     = 50;
  localparam int ACCEPT  = 16;
  localparam int RETRIES = 2;

  localparam int M_NORMAL = 0;
  localparam int M_HIGH   = 1;
  localparam int M_LOW    = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        i2c_idle;
  logic [23:0] i2c_din;
  logic        i2c_wr;
  logic        busy;
  logic        done;
  logic        error;
  logic [3:0]  cfg_index;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  int mode   = M_NORMAL;
  int release_cyc = 0;

  int          strobe_cyc[$];
  logic [23:0] strobe_din[$];
  logic [3:0]  strobe_idx[$];
  int          rise_cyc[$];

  bit          in_xfer;
  bit          din_moved;
  bit          prev_wr;
  logic [23:0] held_din;
  int          acc_dly;
  int          busy_left;
  int          dly;

  logic [23:0] exp_words [11];

  wm8731_cfg_seq #(
    .DEV_ADDR      (8'h34),
    .STARTUP_CYCLES(STARTUP),
    .GAP_CYCLES    (GAP),
    .ACCEPT_CYCLES (ACCEPT),
    .MAX_RETRY     (RETRIES),
    .AUTO_START    (1'b1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .i2c_idle (i2c_idle),
    .i2c_din  (i2c_din),
    .i2c_wr   (i2c_wr),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .cfg_index(cfg_index)
  );

  // Free-running clock and cycle stamp.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor followed by the i2cc stand-in, both on the falling edge so the
  // monitor always sees outputs settled and the model's idle changes are
  // ready for the next rising edge.
  always @(negedge clk) begin
    if (!reset) begin
      in_xfer   = 1'b0;
      din_moved = 1'b0;
      prev_wr   = 1'b0;
      acc_dly   = 0;
      busy_left = 0;
      if (mode == M_NORMAL) i2c_idle = 1'b1;
    end else begin
      if (prev_wr) begin
        checks++;
        if (i2c_wr !== 1'b0) begin
          fails++;
          $display("[TB] FAIL strobe_width: i2c_wr=%b at cycle %0d, expected 0 after a strobe", i2c_wr, cyc);
        end
      end
      if (i2c_wr === 1'b1) begin
        strobe_cyc.push_back(cyc);
        strobe_din.push_back(i2c_din);
        strobe_idx.push_back(cfg_index);
        checks++;
        if (busy !== 1'b1) begin
          fails++;
          $display("[TB] FAIL busy_at_strobe: busy=%b at cycle %0d, expected 1", busy, cyc);
        end
        if (!in_xfer) begin
          in_xfer   = 1'b1;
          held_din  = i2c_din;
          din_moved = 1'b0;
        end
      end
      if (in_xfer && (i2c_din !== held_din)) din_moved = 1'b1;
      prev_wr = i2c_wr;

      case (mode)
        M_HIGH: i2c_idle = 1'b1;
        M_LOW:  i2c_idle = 1'b0;
        default: begin
          if (acc_dly > 0) begin
            acc_dly--;
            if (acc_dly == 0) begin
              i2c_idle  = 1'b0;
              busy_left = $urandom_range(200, 30);
            end
          end else if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) begin
              i2c_idle = 1'b1;
              rise_cyc.push_back(cyc);
              if (in_xfer) begin
                checks++;
                if (din_moved) begin
                  fails++;
                  $display("[TB] FAIL din_stable: i2c_din changed during transfer, now %h, held %h", i2c_din, held_din);
                end
                in_xfer = 1'b0;
              end
            end
          end else if (i2c_wr === 1'b1) begin
            dly = $urandom_range(4, 0);
            if (dly == 0) begin
              i2c_idle  = 1'b0;
              busy_left = $urandom_range(200, 30);
            end else begin
              acc_dly = dly;
            end
          end
        end
      endcase
    end
  end

  // Stimulus helpers. All are entered and left one time unit after a rising edge.
  task automatic clear_log();
    strobe_cyc.delete();
    strobe_din.delete();
    strobe_idx.delete();
    rise_cyc.delete();
    in_xfer   = 1'b0;
    din_moved = 1'b0;
    acc_dly   = 0;
    busy_left = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_strobes(input int n, input int budget, output bit ok);
    int k = 0;
    while (strobe_cyc.size() < n && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    ok = (strobe_cyc.size() >= n);
  endtask

  task automatic wait_rises(input int n, input int budget, output bit ok);
    int k = 0;
    while (rise_cyc.size() < n && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    ok = (rise_cyc.size() >= n);
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int k = 0;
    while (done !== 1'b1 && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    ok = (done === 1'b1);
  endtask

  task automatic wait_error(input int budget, output bit ok);
    int k = 0;
    while (error !== 1'b1 && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    ok = (error === 1'b1);
  endtask

  // Outputs during reset, then release and confirm no strobe right after it.
  task automatic test_reset();
    reset = 1'b1;
    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({i2c_din, i2c_wr, busy, done, error, cfg_index} !== 32'd0) begin
      fails++;
      $display("[TB] FAIL reset_outputs: din=%h wr=%b busy=%b done=%b error=%b idx=%0d, expected all 0",
               i2c_din, i2c_wr, busy, done, error, cfg_index);
    end
    clear_log();
    reset = 1'b0;
    reset = 1'b1;
    release_cyc = cyc;
    @(posedge clk); #1;
    checks++;
    if (i2c_wr !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_release: wr=%b busy=%b, expected 0 0", i2c_wr, busy);
    end
  endtask

  // Automatic run after reset: startup latency, word order, gap latency, flags.
  task automatic test_auto_run();
    bit ok;
    wait_strobes(11, 8000, ok);
    checks++;
    if (!ok) begin
      fails++;
      $display("[TB] FAIL auto_strobes_timeout: got %0d strobes, expected 11", strobe_cyc.size());
    end
    wait_done(600, ok);
    checks++;
    if (!ok) begin
      fails++;
      $display("[TB] FAIL auto_done_timeout: done=%b, expected 1", done);
    end
    checks++;
    if (strobe_cyc.size() != 11) begin
      fails++;
      $display("[TB] FAIL auto_strobe_count: got %0d, expected 11", strobe_cyc.size());
    end
    if (strobe_cyc.size() > 0) begin
      checks++;
      if (strobe_cyc[0] != release_cyc + STARTUP + 2) begin
        fails++;
        $display("[TB] FAIL startup_latency: got %0d cycles, expected %0d", strobe_cyc[0] - release_cyc, STARTUP + 2);
      end
    end
    for (int i = 0; i < strobe_cyc.size() && i < 11; i++) begin
      checks++;
      if (strobe_din[i] !== exp_words[i]) begin
        fails++;
        $display("[TB] FAIL auto_word[%0d]: got %h, expected %h", i, strobe_din[i], exp_words[i]);
      end
      checks++;
      if (strobe_idx[i] !== 4'(i)) begin
        fails++;
        $display("[TB] FAIL auto_index[%0d]: got %0d, expected %0d", i, strobe_idx[i], i);
      end
    end
    for (int i = 0; i + 1 < strobe_cyc.size() && i < rise_cyc.size(); i++) begin
      checks++;
      if (strobe_cyc[i+1] - rise_cyc[i] != GAP + 2) begin
        fails++;
        $display("[TB] FAIL gap_latency[%0d]: got %0d cycles, expected %0d", i, strobe_cyc[i+1] - rise_cyc[i], GAP + 2);
      end
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || error !== 1'b0 || cfg_index !== 4'd10) begin
      fails++;
      $display("[TB] FAIL auto_final: done=%b busy=%b error=%b idx=%0d, expected 1 0 0 10", done, busy, error, cfg_index);
    end
  endtask

  // Rerun via start; a start during entry 5 and a start on the finishing cycle are ignored.
  task automatic test_rerun();
    bit ok;
    int r;
    clear_log();
    pulse_start();
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("[TB] FAIL rerun_start: done=%b busy=%b, expected 0 1", done, busy);
    end
    wait_strobes(6, 4000, ok);
    pulse_start();
    wait_rises(11, 8000, ok);
    checks++;
    if (!ok) begin
      fails++;
      $display("[TB] FAIL rerun_timeout: got %0d transfers, expected 11", rise_cyc.size());
    end
    if (rise_cyc.size() >= 11) begin
      r = rise_cyc[10];
      while (cyc < r + GAP) begin
        @(posedge clk); #1;
      end
      pulse_start();
      checks++;
      if (done !== 1'b1 || busy !== 1'b0) begin
        fails++;
        $display("[TB] FAIL finish_start: done=%b busy=%b, expected 1 0", done, busy);
      end
    end
    repeat (100) @(posedge clk);
    #1;
    checks++;
    if (strobe_cyc.size() != 11 || busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL rerun_count: got %0d strobes busy=%b, expected 11 0", strobe_cyc.size(), busy);
    end
    for (int i = 0; i < strobe_cyc.size() && i < 11; i++) begin
      checks++;
      if (strobe_din[i] !== exp_words[i]) begin
        fails++;
        $display("[TB] FAIL rerun_word[%0d]: got %h, expected %h", i, strobe_din[i], exp_words[i]);
      end
    end
  endtask

  // i2cc never accepts: initial strobe plus retries, then sticky error.
  task automatic test_timeout();
    bit ok;
    clear_log();
    mode = M_HIGH;
    pulse_start();
    wait_error(300, ok);
    checks++;
    if (!ok) begin
      fails++;
      $display("[TB] FAIL timeout_error: error=%b, expected 1", error);
    end
    repeat (50) @(posedge clk);
    #1;
    checks++;
    if (strobe_cyc.size() != RETRIES + 1) begin
      fails++;
      $display("[TB] FAIL timeout_strobes: got %0d, expected %0d", strobe_cyc.size(), RETRIES + 1);
    end
    for (int i = 0; i + 1 < strobe_cyc.size(); i++) begin
      checks++;
      if (strobe_cyc[i+1] - strobe_cyc[i] != ACCEPT + 1) begin
        fails++;
        $display("[TB] FAIL retry_spacing[%0d]: got %0d, expected %0d", i, strobe_cyc[i+1] - strobe_cyc[i], ACCEPT + 1);
      end
    end
    checks++;
    if (error !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || cfg_index !== 4'd0) begin
      fails++;
      $display("[TB] FAIL timeout_final: error=%b busy=%b done=%b idx=%0d, expected 1 0 0 0", error, busy, done, cfg_index);
    end
    mode = M_NORMAL;
    i2c_idle = 1'b1;
  endtask

  // Idle held low in LOAD: no strobe until it rises, then strobe one cycle later.
  task automatic test_idle_hold();
    bit ok;
    int c;
    clear_log();
    mode = M_LOW;
    i2c_idle = 1'b0;
    pulse_start();
    checks++;
    if (error !== 1'b0) begin
      fails++;
      $display("[TB] FAIL start_clears_error: error=%b, expected 0", error);
    end
    repeat (500) @(posedge clk);
    #1;
    checks++;
    if (strobe_cyc.size() != 0 || busy !== 1'b1 || cfg_index !== 4'd0) begin
      fails++;
      $display("[TB] FAIL hold_no_strobe: strobes=%0d busy=%b idx=%0d, expected 0 1 0", strobe_cyc.size(), busy, cfg_index);
    end
    mode = M_NORMAL;
    i2c_idle = 1'b1;
    c = cyc;
    wait_strobes(1, 10, ok);
    checks++;
    if (!ok || strobe_cyc[0] != c + 1) begin
      fails++;
      $display("[TB] FAIL hold_release_latency: got %0d, expected %0d", ok ? strobe_cyc[0] - c : -1, 1);
    end
    if (ok) begin
      checks++;
      if (strobe_din[0] !== exp_words[0]) begin
        fails++;
        $display("[TB] FAIL hold_word: got %h, expected %h", strobe_din[0], exp_words[0]);
      end
    end
    wait_done(8000, ok);
    checks++;
    if (!ok) begin
      fails++;
      $display("[TB] FAIL hold_done: done=%b, expected 1", done);
    end
  endtask

  // Reset during the entry-4 transfer, then the auto-run restarts from entry 0.
  task automatic test_reset_midrun();
    bit ok;
    clear_log();
    pulse_start();
    wait_strobes(5, 4000, ok);
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (cfg_index !== 4'd4 || busy !== 1'b1 || i2c_din !== exp_words[4]) begin
      fails++;
      $display("[TB] FAIL pre_reset: idx=%0d busy=%b din=%h, expected 4 1 %h", cfg_index, busy, i2c_din, exp_words[4]);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({i2c_din, i2c_wr, busy, done, error, cfg_index} !== 32'd0) begin
      fails++;
      $display("[TB] FAIL midrun_reset: din=%h wr=%b busy=%b done=%b error=%b idx=%0d, expected all 0",
               i2c_din, i2c_wr, busy, done, error, cfg_index);
    end
    repeat (3) @(posedge clk);
    #1;
    clear_log();
    reset = 1'b1;
    release_cyc = cyc;
    wait_strobes(1, STARTUP + 20, ok);
    checks++;
    if (!ok || strobe_cyc[0] != release_cyc + STARTUP + 2) begin
      fails++;
      $display("[TB] FAIL restart_latency: got %0d, expected %0d", ok ? strobe_cyc[0] - release_cyc : -1, STARTUP + 2);
    end
    if (ok) begin
      checks++;
      if (strobe_din[0] !== exp_words[0] || strobe_idx[0] !== 4'd0) begin
        fails++;
        $display("[TB] FAIL restart_entry: din=%h idx=%0d, expected %h 0", strobe_din[0], strobe_idx[0], exp_words[0]);
      end
    end
  endtask

  // Test sequence.
  initial begin
    exp_words = '{24'h341E00, 24'h340C00, 24'h340017, 24'h340217, 24'h340479, 24'h340679,
                  24'h340812, 24'h340A00, 24'h340E02, 24'h341000, 24'h341201};
    start    = 1'b0;
    i2c_idle = 1'b1;
    test_reset();
    test_auto_run();
    test_rerun();
    test_timeout();
    test_idle_hold();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/wm8731_cfg_seq.md
Name: wm8731_cfg_seq

Overview:
Upstream configuration sequencer for the i2cc I2C master. After reset, or on request, it walks a fixed 11-entry WM8731 register table. For each entry it builds the 24-bit word {device address, 7-bit register, 9-bit data}, strobes i2cc, and tracks i2cc's idle flag until the transfer completes. It reports busy, done and error to the top-level codec controller.

Parameters:
DEV_ADDR, 8'h34, I2C write address byte (WM8731, CSB=0)
STARTUP_CYCLES, 1000, clk cycles waited after reset release before the first auto-run transfer
GAP_CYCLES, 50, idle clk cycles inserted between consecutive transfers
ACCEPT_CYCLES, 16, cycles after the i2c_wr strobe within which i2c_idle must fall
MAX_RETRY, 2, re-strobes allowed per entry before error
AUTO_START, 1, 1 = run the table automatically after reset

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; rerun the table (ignored while busy)
i2c_idle  in  1  i2cc idle flag (1 = free)
i2c_din  out  24  word to i2cc; held stable for the whole transfer
i2c_wr  out  1  one-cycle write strobe to i2cc
busy  out  1  sequence in progress
done  out  1  sticky; all entries sent; cleared by the next start
error  out  1  sticky; accept timeout after retries exhausted; cleared by the next start
cfg_index  out  4  index of the current or last entry

Behaviour:
- Reset (reset=0, asynchronous): state=RESET_WAIT; i2c_din=0, i2c_wr=0, busy=0, done=0, error=0, cfg_index=0; all counters cleared. Asserting reset mid-transfer aborts immediately; i2c_wr must never be high during or in the cycle after reset release.
- Table (index: reg, data) -> word: 0: R15 000 -> 341E00; 1: R6 000 -> 340C00; 2: R0 017 -> 340017; 3: R1 017 -> 340217; 4: R2 079 -> 340479; 5: R3 079 -> 340679; 6: R4 012 -> 340812; 7: R5 000 -> 340A00; 8: R7 002 -> 340E02; 9: R8 000 -> 341000; 10: R9 001 -> 341201.
- Word format: i2c_din = {DEV_ADDR, reg[6:0], data[8:0]}.
- States:
  - RESET_WAIT: count STARTUP_CYCLES. Then go to LOAD if AUTO_START=1, else IDLE.
  - IDLE: busy=0. start=1 -> clear done/error, cfg_index=0, go to LOAD.
  - LOAD: busy=1; drive i2c_din from the table. If i2c_idle=1, go to STROBE; else stay.
  - STROBE: i2c_wr=1 for exactly this one cycle; go to WAIT_ACC.
  - WAIT_ACC: i2c_idle=0 -> WAIT_DONE. ACCEPT_CYCLES expire with idle still 1 -> if retries<MAX_RETRY, retries+1 and go to STROBE; else error=1 and go to IDLE.
  - WAIT_DONE: i2c_idle=1 -> GAP.
  - GAP: count GAP_CYCLES. Then, if cfg_index=10, done=1 and go to IDLE; else cfg_index+1, retries=0, go to LOAD.
- start while busy: ignored. start in the same cycle the run finishes: ignored; done=1.
- i2c_din changes only in LOAD; it is constant from STROBE through GAP.
- Latency, auto-run: the first i2c_wr occurs STARTUP_CYCLES+2 cycles after reset release, provided i2c_idle=1.
- Latency, between transfers: the next i2c_wr occurs GAP_CYCLES+2 cycles after i2c_idle returns high.

Test Plan:
- Auto-run with an i2cc model (idle low for 200 cycles per write) -> 11 strobes; i2c_din sequence 341E00 ... 341201; done=1, busy=0, cfg_index=10, error=0.
- Strobe spacing check -> each strobe exactly 1 cycle wide; i2c_din is unchanged from each strobe until its transfer's idle rise.
- i2c_idle tied high (no accept) -> 3 strobes spaced ACCEPT_CYCLES+1 apart; then error=1, busy=0, cfg_index=0.
- After done, pulse start -> done clears the next cycle and the sequence reruns from 341E00. A start pulsed while busy (entry 5) has no effect.
- reset low while in WAIT_DONE at entry 4 -> all outputs 0 immediately. After release, the sequence restarts after STARTUP_CYCLES from entry 0.
- i2c_idle held low at LOAD for 500 cycles -> no strobe until idle rises; strobe follows 1 cycle after the rise.
